// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller.
//   NUM_CH       : number of channels behind the 16:1 mux tree
//   SEL_W        : width of the channel select
//   scan_state_t : scan FSM state encoding
package mux_scan_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational priority search for the next enabled channel.
// Ports:
//   i_mask  : channel-enable mask
//   i_idx   : reference channel index
//   i_incl  : 1 = i_idx itself is a candidate, 0 = search strictly above i_idx
//   o_ch    : lowest enabled channel satisfying the search (0 when none)
//   o_found : an enabled channel was found
// The search never wraps: nothing above channel NUM_CH-1 is ever returned.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_idx,
  input  logic              i_incl,
  output logic [SEL_W-1:0]  o_ch,
  output logic              o_found
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    o_ch    = '0;
    o_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && ((i > int'(i_idx)) || (i_incl && (i == int'(i_idx))))) begin
        o_found = 1'b1;
        o_ch    = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 16:1 mux tree. On start it walks the
// enabled channels in ascending order, holds sel for SETTLE_CYCLES cycles,
// then captures mux_out into sample_vec[sel].
// Optional feature: define MUX_SCAN_CONT_EN for continuous mode, where DONE
// re-latches chan_mask and begins a new pass instead of returning to IDLE.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : scan request, honoured only in IDLE
//   chan_mask  : channel-enable mask, latched when a scan begins
//   mux_out    : output of the mux tree
//   sel        : channel select to the mux tree
//   sample_vec : captured channel values, bit i = channel i
//   busy       : controller is not in IDLE
//   done       : one-cycle pulse at scan completion
//   valid      : sample_vec holds a complete scan result
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] sample_vec,
  output logic              busy,
  output logic              done,
  output logic              valid
);

  localparam int CNT_W = 4;

  scan_state_t       r_state;
  scan_state_t       w_next;
  logic [NUM_CH-1:0] r_mask;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_CH-1:0] r_vec;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;

  logic              w_accept;
  logic              w_settled;
  logic [NUM_CH-1:0] w_srch_mask;
  logic [SEL_W-1:0]  w_srch_idx;
  logic              w_srch_incl;
  logic [SEL_W-1:0]  w_ch;
  logic              w_found;

  // One search unit serves both cases: the first channel of a new scan
  // (live mask, index 0 inclusive) and the successor of the channel just
  // sampled (latched mask, strictly above sel).
  always_comb begin
    w_srch_mask = chan_mask;
    w_srch_idx  = '0;
    w_srch_incl = 1'b1;
    if (r_state == SAMPLE) begin
      w_srch_mask = r_mask;
      w_srch_idx  = r_sel;
      w_srch_incl = 1'b0;
    end
  end

  mux_scan_next_ch u_next_ch (
    .i_mask  (w_srch_mask),
    .i_idx   (w_srch_idx),
    .i_incl  (w_srch_incl),
    .o_ch    (w_ch),
    .o_found (w_found)
  );

  assign w_settled = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = w_found ? SETTLE : DONE;
        end
      end
      SETTLE: begin
        if (w_settled) begin
          w_next = SAMPLE;
        end
      end
      SAMPLE: begin
        w_next = w_found ? SETTLE : DONE;
      end
      DONE: begin
`ifdef MUX_SCAN_CONT_EN
        w_accept = 1'b1;
        w_next   = w_found ? SETTLE : DONE;
`else
        w_next   = IDLE;
`endif
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask  <= '0;
      r_sel   <= '0;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mask  <= chan_mask;
        r_vec   <= '0;
        r_valid <= 1'b0;
        r_cnt   <= '0;
        // With an empty mask sel keeps its previous value.
        if (w_found) begin
          r_sel <= w_ch;
        end
      end else if (r_state == SETTLE) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == SAMPLE) begin
        r_vec[r_sel] <= mux_out;
        r_cnt        <= '0;
        if (w_found) begin
          r_sel <= w_ch;
        end
      end
      // valid must already be high during the DONE cycle itself.
      if (w_next == DONE) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign sel        = r_sel;
  assign sample_vec = r_vec;
  assign valid      = r_valid;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl driving a gate-level 16:1 mux tree.
// Build with MUX_SCAN_CONT_EN defined to exercise continuous mode.
module tb_mux_scan_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] chan_mask = '0;
  logic [15:0] mux_in = '0;
  logic        mux_out;
  logic [3:0]  sel;
  logic [15:0] sample_vec;
  logic        busy;
  logic        done;
  logic        valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .chan_mask  (chan_mask),
    .mux_out    (mux_out),
    .sel        (sel),
    .sample_vec (sample_vec),
    .busy       (busy),
    .done       (done),
    .valid      (valid)
  );

  // Gate-level 16:1 mux tree built from AND/OR 2:1 stages.
  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;
  genvar g;
  for (g = 0; g < 8; g++) begin : g_l1
    assign l1[g] = (mux_in[2*g] & ~sel[0]) | (mux_in[2*g+1] & sel[0]);
  end
  for (g = 0; g < 4; g++) begin : g_l2
    assign l2[g] = (l1[2*g] & ~sel[1]) | (l1[2*g+1] & sel[1]);
  end
  for (g = 0; g < 2; g++) begin : g_l3
    assign l3[g] = (l2[2*g] & ~sel[2]) | (l2[2*g+1] & sel[2]);
  end
  assign mux_out = (l3[0] & ~sel[3]) | (l3[1] & sel[3]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popc(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m[i]);
    return n;
  endfunction

  // Single scan with reference expectations from the channel rules:
  // visited channels = set bits ascending, result = mask & inputs,
  // latency = N*(S+1)+1. Optionally re-pulses start mid-scan.
  task automatic run_scan(input string tag, input logic [15:0] m,
                          input logic [15:0] din, input int glitch_at);
    int lat;
    int pulses;
    int q[$];
    int exp_q[$];
    for (int i = 0; i < 16; i++) if (m[i]) exp_q.push_back(i);
    chan_mask = m;
    mux_in    = din;
    start     = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 400) begin
      if (busy && (q.size() == 0 || q[$] != int'(sel))) q.push_back(int'(sel));
      start     = (lat == glitch_at);
      chan_mask = 16'($urandom);
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, popc(m) * (S + 1) + 1);
    check({tag, "_vec"}, sample_vec, m & din);
    check({tag, "_valid"}, valid, 1'b1);
    check({tag, "_busy_done"}, busy, 1'b1);
    check({tag, "_nvisit"}, q.size(), exp_q.size());
    for (int i = 0; i < q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_visit%0d", tag, i), q[i], exp_q[i]);
    pulses = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) pulses++;
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_valid_hold"}, valid, 1'b1);
    check({tag, "_vec_hold"}, sample_vec, m & din);
  endtask

  initial begin
    int n;
    logic [15:0] din;
    #12;
    check("rst_sel", sel, 4'd0);
    check("rst_vec", sample_vec, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", valid, 1'b0);
    #2 rst_n = 1'b1;

`ifdef MUX_SCAN_CONT_EN
    din = 16'hA5C3;
    chan_mask = 16'h000F;
    mux_in = din;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin tick(); n++; end
    check("cont_first_latency", n, 13);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("cont_vec%0d", p), sample_vec, din & 16'h000F);
      check($sformatf("cont_valid%0d", p), valid, 1'b1);
      check($sformatf("cont_busy%0d", p), busy, 1'b1);
      din = 16'($urandom);
      mux_in = din;
      n = 0;
      do begin tick(); n++; end while (!done && n < 100);
      check($sformatf("cont_period%0d", p), n, 13);
    end
`else
    // Full scan, sparse mask, empty mask.
    run_scan("full", 16'hFFFF, 16'hA5C3, 0);
    run_scan("sparse", 16'h8001, 16'hFFFF, 0);
    run_scan("empty", 16'h0000, 16'hFFFF, 0);
    // Start while busy.
    run_scan("busy_start", 16'h0F3C, 16'h5AA5, 3);
    // Randomized masks and inputs.
    for (int k = 0; k < 4; k++)
      run_scan($sformatf("rand%0d", k), 16'($urandom), 16'($urandom), 0);
    // Reset during SETTLE of channel 5.
    chan_mask = 16'hFFFF;
    mux_in = 16'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (sel != 4'd5 && n < 100) begin tick(); n++; end
    check("mid_reach_ch5", sel, 4'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sel", sel, 4'd0);
    check("mid_rst_vec", sample_vec, 16'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    rst_n = 1'b1;
    run_scan("post_reset", 16'h0421, 16'h7FFF, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, legal range 1..15: the number of cycles sel is held before mux_out is sampled.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a scan request, accepted only in IDLE.
REQ-005 SHALL have port chan_mask, input, 16 bits: channel-enable mask, sampled on start accept.
REQ-006 SHALL have port mux_out, input, 1 bit: the output of the downstream 16:1 gate-level mux tree.
REQ-007 SHALL have port sel, output, 4 bits: the channel select driving the mux tree.
REQ-008 SHALL have port sample_vec, output, 16 bits: captured channel values, where bit i is channel i.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse marking scan completion.
REQ-011 SHALL have port valid, output, 1 bit: sample_vec holds a complete scan result.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE and DONE, all registered.
REQ-013 SHALL, in IDLE with start=1, latch chan_mask, clear sample_vec and valid, and then:
- go to SETTLE with sel set to the lowest enabled channel if the mask is nonzero;
- go to DONE if the mask is zero.
REQ-014 SHALL, in SETTLE, hold sel stable and count SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-015 SHALL, in SAMPLE, write mux_out into sample_vec[sel] and then:
- go to SETTLE with sel set to the next higher enabled channel if one exists;
- go to DONE otherwise.
REQ-016 SHALL skip masked-out channels entirely; their sample_vec bits remain 0.
REQ-017 SHALL, in DONE, assert done for exactly one cycle, set valid, and return to IDLE.
REQ-018 SHALL have a scan latency from start accept to the done pulse of N*(SETTLE_CYCLES+1)+1 cycles, where N is the number of enabled channels; with N=0 the latency is 1 cycle.
REQ-019 SHALL ignore start while busy=1, with no queuing and no restart.
REQ-020 SHALL ignore changes to chan_mask during a scan.
REQ-021 SHALL hold sel at its last value in IDLE and DONE.
REQ-022 SHALL never wrap sel from 15 to 0 within a scan; channel 15 is the last channel visited.
REQ-023 SHALL keep valid high from the DONE cycle until the next accepted start.

Reset
REQ-024 SHALL, when rst_n=0 at any time including mid-scan, immediately force:
- state to IDLE;
- sel to 0;
- sample_vec to 0;
- busy, done and valid to 0.
REQ-025 SHALL accept start on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro MUX_SCAN_CONT_EN to select scan mode:
- Defined: DONE transitions directly to a new scan, re-latching chan_mask as if start were asserted; done still pulses each pass, and busy stays high until reset. This is continuous mode.
- Undefined: the block performs a single scan per start, as specified above.

Structure
REQ-027 SHALL take the following from shared package mux_scan_pkg:
- constants NUM_CH=16 and SEL_W=4;
- the FSM state enumeration type.
REQ-028 SHALL contain exactly one sub-module, mux_scan_next_ch: a combinational priority search that returns the next enabled channel above a given index, plus a found flag.

Verification
REQ-029 SHALL include a bench that instantiates the block with the 16:1 gate-level mux tree downstream and covers the scenarios in REQ-030 to REQ-035.
REQ-030 SHALL cover a full scan:
- stimulus: SETTLE_CYCLES=2, chan_mask=16'hFFFF, mux inputs=16'hA5C3, start pulse;
- response: done after 49 cycles, sample_vec=16'hA5C3, valid=1.
REQ-031 SHALL cover a sparse mask:
- stimulus: chan_mask=16'h8001, inputs=16'hFFFF;
- response: sel visits only 0 then 15, sample_vec=16'h8001, done after 7 cycles.
REQ-032 SHALL cover an empty mask:
- stimulus: chan_mask=16'h0000, start;
- response: done 1 cycle later, sample_vec=0, valid=1.
REQ-033 SHALL cover start while busy:
- stimulus: second start pulse mid-scan;
- response: the scan is unaffected, and exactly one done pulse occurs.
REQ-034 SHALL cover reset mid-scan:
- stimulus: rst_n=0 during SETTLE of channel 5;
- response: sel=0, sample_vec=0, busy=0 asynchronously, and a following start scans normally.
REQ-035 SHALL cover continuous mode:
- stimulus: MUX_SCAN_CONT_EN defined, chan_mask=16'h000F, inputs changed between passes;
- response: done pulses every 13 cycles, and sample_vec tracks the new inputs.
